// File: rtl/btn_gate_array_if.sv
// Button/gate bundle for btn_gate_array: raw button inputs towards the block,
// debounced levels, gate result and mode code back out.
interface btn_gate_array_if #(
    parameter int unsigned N = 2
);
    logic [N-1:0] btn;
    logic         btn_mode;
    logic [N-1:0] ld_deb;
    logic         ld_gate;
    logic [2:0]   ld_mode;

    modport master (
        output btn,
        output btn_mode,
        input  ld_deb,
        input  ld_gate,
        input  ld_mode
    );

    modport slave (
        input  btn,
        input  btn_mode,
        output ld_deb,
        output ld_gate,
        output ld_mode
    );
endinterface

// File: rtl/btn_gate_array.sv
// btn_gate_array: N button debouncers plus a debounced mode-step button that
// cycles a gate function (NAND, NOR, AND, OR, XOR, XNOR) applied to the
// debounced levels; the gate result is registered.
// Build option: define BTN_SYNC_EN to put a 2-flop synchronizer in front of
// every debouncer (adds 2 cycles of latency); undefined, raw inputs feed the
// debouncers directly.
module btn_gate_array #(
    parameter int unsigned N          = 2,
    parameter int unsigned DEB_CYCLES = 250000,
    parameter int unsigned CNT_W      = 20
) (
    input logic             clk,
    input logic             rst_n,
    btn_gate_array_if.slave bus
);

    localparam int unsigned      NCH     = N + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic [2:0] {
        ModeNand = 3'd0,
        ModeNor  = 3'd1,
        ModeAnd  = 3'd2,
        ModeOr   = 3'd3,
        ModeXor  = 3'd4,
        ModeXnor = 3'd5
    } mode_e;

    // Channel N is the mode-step button; channels 0..N-1 are the gate inputs.
    logic [N:0] raw;
    logic [N:0] sample;

    assign raw = {bus.btn_mode, bus.btn};

`ifdef BTN_SYNC_EN
    logic [N:0] sync1_q;
    logic [N:0] sync2_q;

    // Two-flop synchronizer for every raw input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    assign sample = sync2_q;
`else
    assign sample = raw;
`endif

    logic [N:0]       state_q;
    logic [N:0]       state_d;
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];

    // Debounce next state: count consecutive differing samples, flip on the last one.
    always_comb begin
        state_d = state_q;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = '0;
            if (sample[i] != state_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    state_d[i] = sample[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Debouncer state and counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    mode_e mode_q;
    mode_e mode_d;
    logic  mode_rise;

    // Step once on the edge where the debounced mode button goes 0 -> 1.
    assign mode_rise = ~state_q[N] & state_d[N];

    // Mode next state: advance through the six codes, wrapping 5 -> 0.
    always_comb begin
        mode_d = mode_q;
        if (mode_rise) begin
            mode_d = (mode_q == ModeXnor) ? ModeNand : mode_e'(mode_q + 3'd1);
        end
    end

    logic [N-1:0] deb;
    logic         gate_q;
    logic         gate_d;

    assign deb = state_q[N-1:0];

    // Gate function selected by the current mode over the current debounced levels.
    always_comb begin
        gate_d = 1'b0;
        case (mode_q)
            ModeNand: gate_d = ~&deb;
            ModeNor:  gate_d = ~|deb;
            ModeAnd:  gate_d = &deb;
            ModeOr:   gate_d = |deb;
            ModeXor:  gate_d = ^deb;
            ModeXnor: gate_d = ~^deb;
            default:  gate_d = 1'b0;
        endcase
    end

    // Mode register and registered gate result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q <= ModeNand;
            gate_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            gate_q <= gate_d;
        end
    end

    assign bus.ld_deb  = deb;
    assign bus.ld_mode = mode_q;
    assign bus.ld_gate = gate_q;

endmodule

// File: tb/tb_btn_gate_array.sv
// Self-checking bench for btn_gate_array (N=2, DEB_CYCLES=4). A behavioural
// model tracks the expected outputs every cycle; directed literal checks pin
// reset, latency, short-pulse rejection, mode stepping and reset mid-press.
// Works with BTN_SYNC_EN defined (S=2) or undefined (S=0).
module tb_btn_gate_array;

    localparam int N   = 2;
    localparam int DEB = 4;
`ifdef BTN_SYNC_EN
    localparam int S = 2;
`else
    localparam int S = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    btn_gate_array_if #(.N(N)) bus ();

    btn_gate_array #(
        .N          (N),
        .DEB_CYCLES (DEB),
        .CNT_W      (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Model state: raw-input delay line, debounced levels, run lengths, mode, gate.
    bit [N:0] m_hist [2];
    bit [N:0] m_state;
    int       m_run [N+1];
    int       m_mode;
    bit       m_gate;

    function automatic bit gate_fn(input int mode, input bit [N-1:0] v);
        int c;
        c = $countones(v);
        case (mode)
            0: return c != N;
            1: return c == 0;
            2: return c == N;
            3: return c != 0;
            4: return (c % 2) == 1;
            5: return (c % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit [N:0] raw);
        bit [N:0] smp;
        if (!r) begin
            m_hist[0] = '0;
            m_hist[1] = '0;
            m_state   = '0;
            m_mode    = 0;
            m_gate    = 1'b0;
            for (int i = 0; i <= N; i++) m_run[i] = 0;
            return;
        end
        smp = (S == 0) ? raw : m_hist[1];
        m_gate = gate_fn(m_mode, m_state[N-1:0]);
        m_hist[1] = m_hist[0];
        m_hist[0] = raw;
        for (int i = 0; i <= N; i++) begin
            if (smp[i] != m_state[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_state[i] = smp[i];
                    m_run[i]   = 0;
                    if (i == N && smp[i]) m_mode = (m_mode + 1) % 6;
                end
            end else begin
                m_run[i] = 0;
            end
        end
    endtask

    // One clock: drive on the falling edge, advance the model at the rising
    // edge, compare shortly after it.
    task automatic step(input bit r, input bit [N-1:0] b, input bit m);
        @(negedge clk);
        rst_n        = r;
        bus.btn      = b;
        bus.btn_mode = m;
        @(posedge clk);
        model_step(r, {m, b});
        #1;
        check("model_deb", int'(bus.ld_deb), int'(m_state[N-1:0]));
        check("model_gate", int'(bus.ld_gate), int'(m_gate));
        check("model_mode", int'(bus.ld_mode), m_mode);
    endtask

    int       exp_mode [7] = '{1, 2, 3, 4, 5, 0, 1};
    bit [N-1:0] rb;
    bit         rm;
    bit         rr;

    initial begin
        bus.btn      = '0;
        bus.btn_mode = 1'b0;

        // Reset values, then NAND of zeros one cycle after release.
        step(0, 2'b00, 0);
        step(0, 2'b00, 0);
        check("rst_deb", int'(bus.ld_deb), 0);
        check("rst_mode", int'(bus.ld_mode), 0);
        check("rst_gate", int'(bus.ld_gate), 0);
        step(1, 2'b00, 0);
        check("release_gate", int'(bus.ld_gate), 1);
        repeat (3) step(1, 2'b00, 0);

        // Both buttons held: debounced after S+DEB edges, gate one edge later.
        for (int j = 1; j <= S + 5; j++) begin
            step(1, 2'b11, 0);
            if (j == S + 3) check("lat_deb_early", int'(bus.ld_deb), 0);
            if (j == S + 4) begin
                check("lat_deb", int'(bus.ld_deb), 3);
                check("lat_gate_old", int'(bus.ld_gate), 1);
            end
            if (j == S + 5) check("lat_gate", int'(bus.ld_gate), 0);
        end
        repeat (3) step(1, 2'b11, 0);
        repeat (10) step(1, 2'b00, 0);
        check("idle_deb", int'(bus.ld_deb), 0);

        // Pulses one cycle short of the hold time are ignored.
        for (int p = 0; p < 10; p++) begin
            repeat (3) step(1, 2'b01, 0);
            repeat (3) step(1, 2'b00, 0);
            check("pulse_deb", int'(bus.ld_deb), 0);
            check("pulse_gate", int'(bus.ld_gate), 1);
        end
        repeat (4) step(1, 2'b00, 0);

        // Reset mid-press discards the partial count.
        repeat (S + 3) step(1, 2'b10, 0);
        step(0, 2'b10, 0);
        check("midrst_deb", int'(bus.ld_deb), 0);
        for (int j = 1; j <= S + 4; j++) begin
            step(1, 2'b10, 0);
            if (j == S + 3) check("midrst_deb_early", int'(bus.ld_deb[1]), 0);
            if (j == S + 4) check("midrst_deb_late", int'(bus.ld_deb[1]), 1);
        end

        // Mode stepping: one step per press, holding never repeats.
        repeat (20) step(1, 2'b01, 0);
        check("pre_mode", int'(bus.ld_mode), 0);
        for (int p = 0; p < 7; p++) begin
            repeat (100) step(1, 2'b01, 1);
            check("mode_step", int'(bus.ld_mode), exp_mode[p]);
            if (p == 3) check("xor_gate", int'(bus.ld_gate), 1);
            repeat (100) step(1, 2'b01, 0);
            check("mode_hold", int'(bus.ld_mode), exp_mode[p]);
        end

        // Randomized phase: slow-changing inputs with occasional reset.
        rb = '0;
        rm = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(4) == 0) rb[i] = ~rb[i];
            end
            if ($urandom_range(4) == 0) rm = ~rm;
            rr = ($urandom_range(299) != 0);
            step(rr, rb, rm);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/btn_gate_array.md
BTN_GATE_ARRAY -- requirements
Module: btn_gate_array

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 Parameter N, default 2: number of button channels, legal range 2..8.
REQ-003 Parameter DEB_CYCLES, default 250000: debounce hold time in clk cycles, legal range 2..2^20.
REQ-004 Parameter CNT_W, default 20: debounce counter width, SHALL satisfy 2^CNT_W >= DEB_CYCLES.
REQ-005 Port clk, input, 1 bit: system clock; all state SHALL update on its rising edge.
REQ-006 Port rst_n, input, 1 bit: synchronous active-low reset.
REQ-007 Port btn, input, N bits: raw, bouncing, asynchronous push-buttons.
REQ-008 Port btn_mode, input, 1 bit: raw, bouncing mode-step button.
REQ-009 Port ld_deb, output, N bits: debounced button levels.
REQ-010 Port ld_gate, output, 1 bit: registered gate result over all N debounced levels.
REQ-011 Port ld_mode, output, 3 bits: current gate mode code.

Function
REQ-012 Each of the N+1 inputs SHALL have its own debouncer with a state bit and a CNT_W-bit counter.
REQ-013 Debouncer, sample equals state: the counter SHALL clear to 0.
REQ-014 Debouncer, sample differs from state: the counter SHALL increment by 1.
REQ-015 Debouncer, sample differs and counter equals DEB_CYCLES-1: the state SHALL take the sample value and the counter SHALL clear.
REQ-016 A difference held for DEB_CYCLES consecutive cycles SHALL flip the state; any shorter pulse SHALL leave the state unchanged.
REQ-017 The counter SHALL never wrap; it is bounded by REQ-015.
REQ-018 ld_deb[i] SHALL equal the state bit of debouncer i.
REQ-019 The mode register SHALL advance on a 0->1 transition of the debounced btn_mode state only, one step per press; holding the button SHALL not repeat.
REQ-020 Mode sequence: 0 NAND, 1 NOR, 2 AND, 3 OR, 4 XOR (odd parity), 5 XNOR; 5 SHALL wrap to 0.
REQ-021 Codes 6 and 7 SHALL never be entered.
REQ-022 ld_mode SHALL equal the mode register.
REQ-023 ld_gate SHALL be registered: each cycle it loads the function selected by the mode register, applied to the current ld_deb vector.
REQ-024 Latency: ld_gate SHALL reflect a change of ld_deb or ld_mode exactly 1 cycle later.
REQ-025 If ld_deb and ld_mode change in the same cycle, ld_gate SHALL use both new values on the next cycle, with no intermediate value.
REQ-026 Debouncers SHALL be independent; simultaneous presses on several channels SHALL each resolve per REQ-016.

Reset
REQ-027 While rst_n=0 at a clk edge, all of the following SHALL clear to 0: debouncer states, counters, synchronizer flops, mode register, ld_gate.
REQ-028 Reset outputs: ld_deb=0, ld_mode=0 (NAND), ld_gate=0.
REQ-029 On the first cycle after release, ld_gate SHALL become 1 (NAND of all zeros).
REQ-030 Reset asserted mid-debounce or mid-press SHALL discard the partial count; no mode step SHALL occur on release.

Configuration
REQ-031 Macro BTN_SYNC_EN, defined: each raw input SHALL pass through a 2-flop synchronizer before its debouncer.
REQ-032 With BTN_SYNC_EN defined, latency from a stable raw change to ld_deb SHALL be S+DEB_CYCLES cycles, with S=2.
REQ-033 With BTN_SYNC_EN undefined, raw inputs SHALL feed the debouncers directly, with S=0; all other behaviour is identical.

Verification (N=2, DEB_CYCLES=4, BTN_SYNC_EN defined)
REQ-034 Reset then release, btn=00 -> ld_deb=00, ld_mode=0, ld_gate=0 during reset; ld_gate=1 one cycle after release.
REQ-035 btn=11 held from cycle t -> ld_deb=11 at t+6; ld_gate=0 at t+7.
REQ-036 btn[0] pulses high for 3 cycles, 10 times -> ld_deb and ld_gate never change.
REQ-037 btn_mode pressed and held 100 cycles, 7 times -> ld_mode steps 1,2,3,4,5,0,1, once per press; with btn=01 in mode 4, ld_gate=1.
REQ-038 rst_n low for 1 cycle at count 3 of a btn[1] press -> ld_deb[1] stays 0 and its count restarts; with the macro undefined, the REQ-035 latency becomes t+4 and t+5.
